// File: rtl/bp_be_dual_issue_pairer_pkg.sv
// Shared types for the dual-issue pairer: FSM state and execution pipe class.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_pair_empty  = 2'd0,
    e_pair_pair   = 2'd1,
    e_pair_single = 2'd2
  } pairer_state_e;

  typedef enum logic [1:0] {
    e_pipe_int    = 2'd0,
    e_pipe_mem    = 2'd1,
    e_pipe_long   = 2'd2,
    e_pipe_serial = 2'd3
  } pipe_class_e;

  // Two slots may share a pipe only if that pipe is the integer one; serial ops never pair.
  function automatic logic classes_conflict(input pipe_class_e a, input pipe_class_e b);
    return (a == e_pipe_serial) || (b == e_pipe_serial) ||
           ((a == b) && (a != e_pipe_int));
  endfunction

endpackage

// File: rtl/bp_be_dual_issue_pairer_if.sv
// Issue-queue, scoreboard and dispatch signals of the pairer, grouped as one bundle.
interface bp_be_dual_issue_pairer_if #(
  parameter int num_rs_p         = 2,
  parameter int reg_addr_width_p = 5,
  parameter int instr_width_p    = 64
);
  localparam int rs_w_lp = num_rs_p * reg_addr_width_p;

  logic                          pair_v_i;
  logic                          pair_ready_o;
  logic [1:0]                    slot_v_i;
  logic [2*rs_w_lp-1:0]          slot_rs_i;
  logic [2*reg_addr_width_p-1:0] slot_rd_i;
  logic [1:0]                    slot_rd_w_v_i;
  logic [3:0]                    slot_class_i;
  logic [2*instr_width_p-1:0]    slot_instr_i;
  logic [rs_w_lp-1:0]            sb_rs_o1;
  logic [rs_w_lp-1:0]            sb_rs_o2;
  logic [reg_addr_width_p-1:0]   sb_rd_o1;
  logic [reg_addr_width_p-1:0]   sb_rd_o2;
  logic [num_rs_p-1:0]           sb_rs_match_i1;
  logic [num_rs_p-1:0]           sb_rs_match_i2;
  logic                          sb_rd_match_i1;
  logic                          sb_rd_match_i2;
  logic                          score_v_o1;
  logic                          score_v_o2;
  logic [reg_addr_width_p-1:0]   score_rd_o1;
  logic [reg_addr_width_p-1:0]   score_rd_o2;
  logic                          dispatch_ready_i;
  logic [1:0]                    dispatch_v_o;
  logic [2*instr_width_p-1:0]    dispatch_instr_o;
  logic                          flush_i;

  modport slave (
    input  pair_v_i, slot_v_i, slot_rs_i, slot_rd_i, slot_rd_w_v_i, slot_class_i,
           slot_instr_i, sb_rs_match_i1, sb_rs_match_i2, sb_rd_match_i1,
           sb_rd_match_i2, dispatch_ready_i, flush_i,
    output pair_ready_o, sb_rs_o1, sb_rs_o2, sb_rd_o1, sb_rd_o2, score_v_o1,
           score_v_o2, score_rd_o1, score_rd_o2, dispatch_v_o, dispatch_instr_o
  );

  modport master (
    output pair_v_i, slot_v_i, slot_rs_i, slot_rd_i, slot_rd_w_v_i, slot_class_i,
           slot_instr_i, sb_rs_match_i1, sb_rs_match_i2, sb_rd_match_i1,
           sb_rd_match_i2, dispatch_ready_i, flush_i,
    input  pair_ready_o, sb_rs_o1, sb_rs_o2, sb_rd_o1, sb_rd_o2, score_v_o1,
           score_v_o2, score_rd_o1, score_rd_o2, dispatch_v_o, dispatch_instr_o
  );
endinterface

// File: rtl/bp_be_dual_issue_pairer_conflict.sv
// Combinational co-issue check: x0-masked scoreboard hazards plus pipe-class pairing rules.
module bp_be_pair_conflict
  import bp_be_pkg::*;
#(
  parameter int num_rs_p         = 2,
  parameter int reg_addr_width_p = 5
) (
  input  logic [num_rs_p*reg_addr_width_p-1:0] i_rs1,
  input  logic [num_rs_p*reg_addr_width_p-1:0] i_rs2,
  input  logic [reg_addr_width_p-1:0]          i_rd1,
  input  logic [reg_addr_width_p-1:0]          i_rd2,
  input  logic [num_rs_p-1:0]                  i_rs_match1,
  input  logic [num_rs_p-1:0]                  i_rs_match2,
  input  logic                                 i_rd_match1,
  input  logic                                 i_rd_match2,
  input  pipe_class_e                          i_class1,
  input  pipe_class_e                          i_class2,
  output logic                                 o_hazard1,
  output logic                                 o_pair_legal
);
  logic [num_rs_p-1:0] w_rs_hit1;
  logic [num_rs_p-1:0] w_rs_hit2;
  logic                w_hazard2;

  genvar gi;
  generate
    for (gi = 0; gi < num_rs_p; gi++) begin : g_rs_mask
      assign w_rs_hit1[gi] = i_rs_match1[gi] &
                             (i_rs1[gi*reg_addr_width_p +: reg_addr_width_p] != '0);
      assign w_rs_hit2[gi] = i_rs_match2[gi] &
                             (i_rs2[gi*reg_addr_width_p +: reg_addr_width_p] != '0);
    end
  endgenerate

  assign o_hazard1    = (|w_rs_hit1) | (i_rd_match1 & (i_rd1 != '0));
  assign w_hazard2    = (|w_rs_hit2) | (i_rd_match2 & (i_rd2 != '0));
  assign o_pair_legal = !w_hazard2 && !classes_conflict(i_class1, i_class2);
endmodule

// File: rtl/bp_be_dual_issue_pairer.sv
// Issue-stage pair holder: latches a pair, probes the scoreboard, dispatches 0/1/2 per cycle.
module bp_be_dual_issue_pairer
  import bp_be_pkg::*;
#(
  parameter int num_rs_p         = 2,
  parameter int reg_addr_width_p = 5,
  parameter int instr_width_p    = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_be_dual_issue_pairer_if.slave pif
);
  localparam int rs_w_lp = num_rs_p * reg_addr_width_p;

  pairer_state_e               r_state;
  logic [rs_w_lp-1:0]          r_rs    [2];
  logic [reg_addr_width_p-1:0] r_rd    [2];
  logic [1:0]                  r_rd_w_v;
  pipe_class_e                 r_cls   [2];
  logic [instr_width_p-1:0]    r_instr [2];

  logic [rs_w_lp-1:0]          w_in_rs    [2];
  logic [reg_addr_width_p-1:0] w_in_rd    [2];
  pipe_class_e                 w_in_cls   [2];
  logic [instr_width_p-1:0]    w_in_instr [2];
  logic                        w_src0;
  logic                        w_held, w_pair;
  logic                        w_hazard1, w_pair_legal;
  logic                        w_issue1, w_issue2, w_all_issue;
  logic                        w_accept, w_split;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      assign w_in_rs[gi]    = pif.slot_rs_i[gi*rs_w_lp +: rs_w_lp];
      assign w_in_rd[gi]    = pif.slot_rd_i[gi*reg_addr_width_p +: reg_addr_width_p];
      assign w_in_cls[gi]   = pipe_class_e'(pif.slot_class_i[gi*2 +: 2]);
      assign w_in_instr[gi] = pif.slot_instr_i[gi*instr_width_p +: instr_width_p];
    end
  endgenerate

  // A pair arriving with only the younger slot valid is held in the port-1 position.
  assign w_src0 = (pif.slot_v_i == 2'b10);
  assign w_held = (r_state != e_pair_empty);
  assign w_pair = (r_state == e_pair_pair);

  assign pif.sb_rs_o1 = w_held ? r_rs[0] : '0;
  assign pif.sb_rd_o1 = w_held ? r_rd[0] : '0;
  assign pif.sb_rs_o2 = w_pair ? r_rs[1] : '0;
  assign pif.sb_rd_o2 = w_pair ? r_rd[1] : '0;

  bp_be_pair_conflict #(
    .num_rs_p        (num_rs_p),
    .reg_addr_width_p(reg_addr_width_p)
  ) u_conflict (
    .i_rs1       (pif.sb_rs_o1),
    .i_rs2       (pif.sb_rs_o2),
    .i_rd1       (pif.sb_rd_o1),
    .i_rd2       (pif.sb_rd_o2),
    .i_rs_match1 (pif.sb_rs_match_i1),
    .i_rs_match2 (pif.sb_rs_match_i2),
    .i_rd_match1 (pif.sb_rd_match_i1),
    .i_rd_match2 (pif.sb_rd_match_i2),
    .i_class1    (r_cls[0]),
    .i_class2    (r_cls[1]),
    .o_hazard1   (w_hazard1),
    .o_pair_legal(w_pair_legal)
  );

  assign w_issue1    = w_held & !w_hazard1 & pif.dispatch_ready_i & !pif.flush_i;
  assign w_issue2    = w_pair & w_issue1 & w_pair_legal;
  assign w_all_issue = w_pair ? w_issue2 : w_issue1;
  assign w_split     = w_pair & w_issue1 & !w_issue2;

  assign pif.pair_ready_o = !pif.flush_i & (!w_held | w_all_issue);
  assign w_accept         = pif.pair_v_i & pif.pair_ready_o;

  assign pif.dispatch_v_o = {w_issue2, w_issue1};
  assign pif.dispatch_instr_o = {(w_issue2 ? r_instr[1] : '0), (w_issue1 ? r_instr[0] : '0)};
  assign pif.score_v_o1  = w_issue1 & r_rd_w_v[0] & (r_rd[0] != '0);
  assign pif.score_v_o2  = w_issue2 & r_rd_w_v[1] & (r_rd[1] != '0);
  assign pif.score_rd_o1 = pif.score_v_o1 ? r_rd[0] : '0;
  assign pif.score_rd_o2 = pif.score_v_o2 ? r_rd[1] : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= e_pair_empty;
      r_rd_w_v <= '0;
      for (int i = 0; i < 2; i++) begin
        r_rs[i]    <= '0;
        r_rd[i]    <= '0;
        r_cls[i]   <= e_pipe_int;
        r_instr[i] <= '0;
      end
    end else if (pif.flush_i) begin
      r_state  <= e_pair_empty;
      r_rd_w_v <= '0;
    end else if (w_accept) begin
      case (pif.slot_v_i)
        2'b11:        r_state <= e_pair_pair;
        2'b01, 2'b10: r_state <= e_pair_single;
        default:      r_state <= e_pair_empty;
      endcase
      r_rs[0]     <= w_in_rs[w_src0];
      r_rd[0]     <= w_in_rd[w_src0];
      r_cls[0]    <= w_in_cls[w_src0];
      r_instr[0]  <= w_in_instr[w_src0];
      r_rd_w_v[0] <= pif.slot_rd_w_v_i[w_src0];
      r_rs[1]     <= w_in_rs[1];
      r_rd[1]     <= w_in_rd[1];
      r_cls[1]    <= w_in_cls[1];
      r_instr[1]  <= w_in_instr[1];
      r_rd_w_v[1] <= pif.slot_rd_w_v_i[1];
    end else if (w_split) begin
      // Younger instruction moves to the port-1 position and is retried alone.
      r_state     <= e_pair_single;
      r_rs[0]     <= r_rs[1];
      r_rd[0]     <= r_rd[1];
      r_cls[0]    <= r_cls[1];
      r_instr[0]  <= r_instr[1];
      r_rd_w_v[0] <= r_rd_w_v[1];
    end else if (w_all_issue) begin
      r_state <= e_pair_empty;
    end
  end
endmodule
